// File: rtl/flag_cdc_arbiter_if.sv
// rtl/flag_cdc_arbiter_if.sv - requester/crosser signal bundle for flag_cdc_arbiter
interface flag_cdc_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
);
  logic             enable;
  logic [N_REQ-1:0] req;
  logic             cnt_clr;
  logic             cdc_busy;
  logic             cdc_pulse;
  logic [ID_W-1:0]  cdc_id;
  logic [N_REQ-1:0] pending;
  logic             idle;
  logic [CNT_W-1:0] coalesce_cnt;
  logic             err_timeout;

  modport master (
    output enable, req, cnt_clr, cdc_busy,
    input  cdc_pulse, cdc_id, pending, idle, coalesce_cnt, err_timeout
  );

  modport slave (
    input  enable, req, cnt_clr, cdc_busy,
    output cdc_pulse, cdc_id, pending, idle, coalesce_cnt, err_timeout
  );
endinterface

// File: rtl/flag_cdc_arbiter.sv
// rtl/flag_cdc_arbiter.sv - round-robin arbiter sharing one toggle flag crosser among event sources
module flag_cdc_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int TIMEOUT_W = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  flag_cdc_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PULSE, GUARD, WAIT} state_t;

  localparam int PC_W  = $clog2(N_REQ + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  // Last WAIT count value before giving up: exit after 2**TIMEOUT_W-1 WAIT cycles.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  state_t               state, state_nxt;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      start;
  logic [ID_W:0]        gsum;
  logic [ID_W-1:0]      grant;
  logic                 found;
  logic                 launch;
  logic                 timeout_hit;
  logic [N_REQ-1:0]     rot;
  logic [N_REQ-1:0]     clr_mask;
  logic [N_REQ-1:0]     merge;
  logic [N_REQ-1:0]     pending_q;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [SUM_W-1:0]     cnt_sum;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic                 pulse_q, idle_q, err_q;
  logic [ID_W-1:0]      id_q;

  // Rotate pending so bit 0 is the slot just after the last grant, then take the first set bit.
  always_comb begin
    start = (rr_ptr == ID_W'(N_REQ - 1)) ? '0 : rr_ptr + 1'b1;
    rot   = N_REQ'({pending_q, pending_q} >> start);
    found = 1'b0;
    gsum  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        gsum  = {1'b0, start} + (ID_W + 1)'(j);
      end
    end
    if (gsum >= (ID_W + 1)'(N_REQ)) gsum = gsum - (ID_W + 1)'(N_REQ);
    grant    = gsum[ID_W-1:0];
    launch   = (state == IDLE) && bus.enable && found;
    clr_mask = launch ? (N_REQ'(1) << grant) : '0;
    merge    = bus.req & pending_q & ~clr_mask;
  end

  always_comb begin
    cnt_sum = SUM_W'(cnt_q);
    for (int j = 0; j < N_REQ; j++) begin
      cnt_sum = cnt_sum + SUM_W'(merge[j]);
    end
    if (bus.cnt_clr)
      cnt_nxt = '0;
    else if (cnt_sum > SUM_W'({CNT_W{1'b1}}))
      cnt_nxt = '1;
    else
      cnt_nxt = cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // GUARD deliberately skips cdc_busy: the crosser only raises busy a cycle after the launch.
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:  if (launch) state_nxt = PULSE;
      PULSE: state_nxt = GUARD;
      GUARD: state_nxt = WAIT;
      WAIT: begin
        if (!bus.cdc_busy) begin
          state_nxt = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt   = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rr_ptr    <= ID_W'(N_REQ - 1);
      id_q      <= '0;
      pulse_q   <= 1'b0;
      idle_q    <= 1'b1;
      tmo_cnt   <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_mask) | bus.req;
      cnt_q     <= cnt_nxt;
      if (bus.cnt_clr)  err_q <= 1'b0;
      else if (timeout_hit) err_q <= 1'b1;
      if (launch) begin
        rr_ptr <= grant;
        id_q   <= grant;
      end
      pulse_q <= (state_nxt == PULSE);
      idle_q  <= (state_nxt == IDLE);
      if (state == GUARD)     tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign bus.cdc_pulse    = pulse_q;
  assign bus.cdc_id       = id_q;
  assign bus.pending      = pending_q;
  assign bus.idle         = idle_q;
  assign bus.coalesce_cnt = cnt_q;
  assign bus.err_timeout  = err_q;
endmodule
